// File: rtl/axis_converter_lite_pkg_prm.sv
// Shared constants for the AXI-Stream <-> AXI-Lite converters.
// Latency: n/a (constants only).
// Backpressure: n/a.
package axis_converter_lite_pkg_prm;

  localparam int AXI_DATA_WIDTH = 32;
  localparam int AXI_ADDR_WIDTH = 32;
  localparam logic [AXI_ADDR_WIDTH-1:0] AXI_ADDR = 32'h0000_0001;
  localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/axis_converter_lite_master.sv
// AXI-Stream to AXI-Lite master bridge: stream words become AXI-Lite writes to
// AXI_ADDR; when rd_en is set, AXI_ADDR is polled and OKAY read data is streamed out.
// Latency: write AW/W 1 cycle after stream handshake; m_axis valid 1 cycle after R handshake.
// Backpressure: s_axis_tready low while a write is in flight; no new AR while m_axis word is pending.
//
// Ports:
//   aclk, aresetn          clock, async active-low reset
//   rd_en                  read-poll enable (sampled when the read side is idle)
//   s_axis_*               stream input, one word -> one AXI-Lite write
//   m_axis_*               stream output, one word per OKAY read
//   m_axil_*               AXI-Lite master (AW/W/B/AR/R)
//   wr_err, rd_err         one-cycle pulses on non-OKAY bresp / rresp
module axis_converter_lite_master
  import axis_converter_lite_pkg_prm::*;
(
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        rd_en,
  input  logic [AXI_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  output logic [AXI_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic [AXI_ADDR_WIDTH-1:0]   m_axil_awaddr,
  output logic [2:0]                  m_axil_awprot,
  output logic                        m_axil_awvalid,
  input  logic                        m_axil_awready,
  output logic [AXI_DATA_WIDTH-1:0]   m_axil_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] m_axil_wstrb,
  output logic                        m_axil_wvalid,
  input  logic                        m_axil_wready,
  input  logic [1:0]                  m_axil_bresp,
  input  logic                        m_axil_bvalid,
  output logic                        m_axil_bready,
  output logic [AXI_ADDR_WIDTH-1:0]   m_axil_araddr,
  output logic [2:0]                  m_axil_arprot,
  output logic                        m_axil_arvalid,
  input  logic                        m_axil_arready,
  input  logic [AXI_DATA_WIDTH-1:0]   m_axil_rdata,
  input  logic [1:0]                  m_axil_rresp,
  input  logic                        m_axil_rvalid,
  output logic                        m_axil_rready,
  output logic                        wr_err,
  output logic                        rd_err
);

  localparam logic [1:0] WR_IDLE = 2'd0;
  localparam logic [1:0] WR_REQ  = 2'd1;
  localparam logic [1:0] WR_RESP = 2'd2;

  localparam logic [1:0] RD_IDLE = 2'd0;
  localparam logic [1:0] RD_ADDR = 2'd1;
  localparam logic [1:0] RD_DATA = 2'd2;
  localparam logic [1:0] RD_PUSH = 2'd3;

  // ---------------- write side ----------------
  logic [1:0]                wr_state_q, wr_state_d;
  logic                      s_tready_q, s_tready_d;
  logic                      awvalid_q, awvalid_d;
  logic                      wvalid_q, wvalid_d;
  logic                      bready_q, bready_d;
  logic                      aw_done_q, aw_done_d;
  logic                      w_done_q, w_done_d;
  logic [AXI_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                      wr_err_q, wr_err_d;

  always_comb begin
    wr_state_d = wr_state_q;
    s_tready_d = s_tready_q;
    awvalid_d  = awvalid_q;
    wvalid_d   = wvalid_q;
    bready_d   = bready_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wr_err_d   = 1'b0;
    case (wr_state_q)
      WR_IDLE: begin
        // tready comes up on the first edge after reset, never combinationally.
        s_tready_d = 1'b1;
        if (s_axis_tvalid && s_tready_q) begin
          s_tready_d = 1'b0;
          wdata_d    = s_axis_tdata;
          awaddr_d   = AXI_ADDR;
          awvalid_d  = 1'b1;
          wvalid_d   = 1'b1;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          wr_state_d = WR_REQ;
        end
      end
      WR_REQ: begin
        // AW and W retire independently, in any order or together.
        if (awvalid_q && m_axil_awready) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (wvalid_q && m_axil_wready) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if (aw_done_d && w_done_d) begin
          bready_d   = 1'b1;
          wr_state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        if (bready_q && m_axil_bvalid) begin
          bready_d   = 1'b0;
          wr_err_d   = (m_axil_bresp != RESP_OKAY);  // failed word is dropped, no retry
          s_tready_d = 1'b1;
          wr_state_d = WR_IDLE;
        end
      end
      default: wr_state_d = WR_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_state_q <= WR_IDLE;
      s_tready_q <= 1'b0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wr_err_q   <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      s_tready_q <= s_tready_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      bready_q   <= bready_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wr_err_q   <= wr_err_d;
    end
  end

  // ---------------- read side ----------------
  logic [1:0]                rd_state_q, rd_state_d;
  logic                      arvalid_q, arvalid_d;
  logic                      rready_q, rready_d;
  logic [AXI_ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [AXI_DATA_WIDTH-1:0] m_tdata_q, m_tdata_d;
  logic                      m_tvalid_q, m_tvalid_d;
  logic                      rd_err_q, rd_err_d;

  always_comb begin
    rd_state_d = rd_state_q;
    arvalid_d  = arvalid_q;
    rready_d   = rready_q;
    araddr_d   = araddr_q;
    m_tdata_d  = m_tdata_q;
    m_tvalid_d = m_tvalid_q;
    rd_err_d   = 1'b0;
    case (rd_state_q)
      RD_IDLE: begin
        if (rd_en) begin
          arvalid_d  = 1'b1;
          araddr_d   = AXI_ADDR;
          rd_state_d = RD_ADDR;
        end
      end
      RD_ADDR: begin
        if (arvalid_q && m_axil_arready) begin
          arvalid_d  = 1'b0;
          rready_d   = 1'b1;
          rd_state_d = RD_DATA;
        end
      end
      RD_DATA: begin
        if (rready_q && m_axil_rvalid) begin
          rready_d = 1'b0;
          if (m_axil_rresp == RESP_OKAY) begin
            m_tdata_d  = m_axil_rdata;
            m_tvalid_d = 1'b1;
            rd_state_d = RD_PUSH;
          end else begin
            rd_err_d   = 1'b1;
            rd_state_d = RD_IDLE;
          end
        end
      end
      RD_PUSH: begin
        // Polling pauses here until the downstream consumer takes the word.
        if (m_tvalid_q && m_axis_tready) begin
          m_tvalid_d = 1'b0;
          m_tdata_d  = '0;
          rd_state_d = RD_IDLE;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_state_q <= RD_IDLE;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      araddr_q   <= '0;
      m_tdata_q  <= '0;
      m_tvalid_q <= 1'b0;
      rd_err_q   <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      arvalid_q  <= arvalid_d;
      rready_q   <= rready_d;
      araddr_q   <= araddr_d;
      m_tdata_q  <= m_tdata_d;
      m_tvalid_q <= m_tvalid_d;
      rd_err_q   <= rd_err_d;
    end
  end

  assign s_axis_tready  = s_tready_q;
  assign m_axil_awaddr  = awaddr_q;
  assign m_axil_awprot  = 3'b000;
  assign m_axil_awvalid = awvalid_q;
  assign m_axil_wdata   = wdata_q;
  assign m_axil_wstrb   = '1;
  assign m_axil_wvalid  = wvalid_q;
  assign m_axil_bready  = bready_q;
  assign wr_err         = wr_err_q;
  assign m_axil_araddr  = araddr_q;
  assign m_axil_arprot  = 3'b000;
  assign m_axil_arvalid = arvalid_q;
  assign m_axil_rready  = rready_q;
  assign m_axis_tdata   = m_tdata_q;
  assign m_axis_tvalid  = m_tvalid_q;
  assign rd_err         = rd_err_q;

endmodule

// File: tb/tb_axis_converter_lite_master.sv
// Directed bench for axis_converter_lite_master: the bench plays the AXI-Lite slave
// and the stream source/sink; DUT outputs are sampled on the falling edge.
module tb_axis_converter_lite_master;

  logic        aclk, aresetn, rd_en;
  logic [31:0] s_tdata;
  logic        s_tvalid, s_tready;
  logic [31:0] m_tdata;
  logic        m_tvalid, m_tready;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;
  logic        wr_err, rd_err;

  int checks = 0;
  int errors = 0;

  // slave behaviour knobs
  int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  bit          rand_mode = 0;
  int          m_mode = 1;          // 0: tready low, 1: high, 2: toggle, 3: random
  logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  logic [31:0] r_next = 32'h0;

  // monitor results
  int          aw_cnt = 0, b_cnt = 0, ar_cnt = 0, wr_err_cnt = 0, rd_err_cnt = 0;
  logic [31:0] last_awaddr = '0, last_araddr = '0;
  logic [3:0]  last_wstrb = '0;
  logic [31:0] w_q[$];
  logic [31:0] rx_q[$];

  axis_converter_lite_master dut (
    .aclk(aclk), .aresetn(aresetn), .rd_en(rd_en),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .m_axil_awaddr(awaddr), .m_axil_awprot(awprot), .m_axil_awvalid(awvalid),
    .m_axil_awready(awready), .m_axil_wdata(wdata), .m_axil_wstrb(wstrb),
    .m_axil_wvalid(wvalid), .m_axil_wready(wready), .m_axil_bresp(bresp),
    .m_axil_bvalid(bvalid), .m_axil_bready(bready), .m_axil_araddr(araddr),
    .m_axil_arprot(arprot), .m_axil_arvalid(arvalid), .m_axil_arready(arready),
    .m_axil_rdata(rdata), .m_axil_rresp(rresp), .m_axil_rvalid(rvalid),
    .m_axil_rready(rready), .wr_err(wr_err), .rd_err(rd_err)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- slave / sink processes (drive on falling edge) ----------------
  initial begin : aw_slave
    int d;
    awready = 1'b0;
    forever begin
      @(negedge aclk);
      if (awvalid) begin
        d = rand_mode ? int'($urandom_range(0, 3)) : aw_dly;
        repeat (d) @(negedge aclk);
        awready = 1'b1;
        @(negedge aclk);
        awready = 1'b0;
      end
    end
  end

  initial begin : w_slave
    int d;
    wready = 1'b0;
    forever begin
      @(negedge aclk);
      if (wvalid) begin
        d = rand_mode ? int'($urandom_range(0, 3)) : w_dly;
        repeat (d) @(negedge aclk);
        wready = 1'b1;
        @(negedge aclk);
        wready = 1'b0;
      end
    end
  end

  initial begin : b_slave
    int d;
    bvalid = 1'b0;
    bresp  = 2'b00;
    forever begin
      @(negedge aclk);
      if (bready) begin
        d = rand_mode ? int'($urandom_range(0, 3)) : b_dly;
        repeat (d) @(negedge aclk);
        bvalid = 1'b1;
        bresp  = bresp_cfg;
        @(negedge aclk);
        bvalid = 1'b0;
        bresp  = 2'b00;
      end
    end
  end

  initial begin : ar_slave
    int d;
    arready = 1'b0;
    forever begin
      @(negedge aclk);
      if (arvalid) begin
        d = rand_mode ? int'($urandom_range(0, 3)) : ar_dly;
        repeat (d) @(negedge aclk);
        arready = 1'b1;
        @(negedge aclk);
        arready = 1'b0;
      end
    end
  end

  initial begin : r_slave
    int d;
    rvalid = 1'b0;
    rdata  = '0;
    rresp  = 2'b00;
    forever begin
      @(negedge aclk);
      if (rready) begin
        d = rand_mode ? int'($urandom_range(0, 3)) : r_dly;
        repeat (d) @(negedge aclk);
        rvalid = 1'b1;
        rdata  = r_next;
        rresp  = rresp_cfg;
        r_next = r_next + 32'd1;
        @(negedge aclk);
        rvalid = 1'b0;
        rdata  = '0;
        rresp  = 2'b00;
      end
    end
  end

  initial begin : m_sink
    m_tready = 1'b0;
    forever begin
      @(negedge aclk);
      case (m_mode)
        0:       m_tready = 1'b0;
        1:       m_tready = 1'b1;
        2:       m_tready = ~m_tready;
        default: m_tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- monitor: handshake counting and protocol rules ----------------
  initial begin : monitor
    bit          prev_ok;
    logic        p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_mv, p_mr;
    logic [31:0] p_md;
    prev_ok = 0;
    forever begin
      @(negedge aclk);
      #2;
      if (aresetn) begin
        if (awvalid && awready) begin aw_cnt++; last_awaddr = awaddr; end
        if (wvalid && wready) begin w_q.push_back(wdata); last_wstrb = wstrb; end
        if (bvalid && bready) b_cnt++;
        if (arvalid && arready) begin ar_cnt++; last_araddr = araddr; end
        if (m_tvalid && m_tready) rx_q.push_back(m_tdata);
        if (wr_err) wr_err_cnt++;
        if (rd_err) rd_err_cnt++;
        if (prev_ok) begin
          checks++;
          if ((p_awv && !p_awr && !awvalid) || (p_wv && !p_wr && !wvalid) ||
              (p_arv && !p_arr && !arvalid)) begin
            errors++;
            $display("FAIL axil_valid_hold at %0t: awvalid=%b wvalid=%b arvalid=%b, required to stay 1 until ready",
                     $time, awvalid, wvalid, arvalid);
          end
          checks++;
          if (p_mv && !p_mr && (!m_tvalid || m_tdata !== p_md)) begin
            errors++;
            $display("FAIL m_axis_hold at %0t: tvalid=%b tdata=%h, required 1 / %h", $time, m_tvalid, m_tdata, p_md);
          end
          checks++;
          if (arvalid && m_tvalid) begin
            errors++;
            $display("FAIL ar_while_pending at %0t: arvalid=%b with m_axis tvalid=1, required arvalid=0", $time, arvalid);
          end
        end
        prev_ok = 1;
        p_awv = awvalid; p_awr = awready; p_wv = wvalid; p_wr = wready;
        p_arv = arvalid; p_arr = arready; p_mv = m_tvalid; p_mr = m_tready; p_md = m_tdata;
      end else begin
        prev_ok = 0;
      end
    end
  end

  // ---------------- stimulus helpers (no comparisons inside) ----------------
  task automatic stream_send(input logic [31:0] d, output bit ok);
    ok = 0;
    s_tvalid = 1'b1;
    s_tdata  = d;
    for (int n = 0; n < 100 && !ok; n++) begin
      #2;
      ok = s_tready;
      @(negedge aclk);
    end
    s_tvalid = 1'b0;
  endtask

  task automatic wait_b(input int target, output bit ok);
    ok = 0;
    for (int n = 0; n < 400 && !ok; n++) begin
      @(negedge aclk);
      #3;
      ok = (b_cnt >= target);
    end
    @(negedge aclk);
  endtask

  task automatic wait_rx(input int target, output bit ok);
    ok = 0;
    for (int n = 0; n < 400 && !ok; n++) begin
      @(negedge aclk);
      #3;
      ok = (rx_q.size() >= target);
    end
    @(negedge aclk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(negedge aclk);
    checks++;
    if ({s_tready, awvalid, wvalid, bready, arvalid, rready, m_tvalid, wr_err, rd_err} !== 9'b0) begin
      errors++;
      $display("FAIL reset_ctrl: ready/valid/err = %b, required 000000000",
               {s_tready, awvalid, wvalid, bready, arvalid, rready, m_tvalid, wr_err, rd_err});
    end
    checks++;
    if ({awaddr, araddr, wdata, m_tdata} !== 128'b0) begin
      errors++;
      $display("FAIL reset_data: awaddr=%h araddr=%h wdata=%h tdata=%h, required 0", awaddr, araddr, wdata, m_tdata);
    end
    checks++;
    if (wstrb !== 4'hF || awprot !== 3'b000 || arprot !== 3'b000) begin
      errors++;
      $display("FAIL const_outputs: wstrb=%h awprot=%b arprot=%b, required f/000/000", wstrb, awprot, arprot);
    end
    aresetn = 1'b1;
    #1;
    checks++;
    if (s_tready !== 1'b0) begin
      errors++;
      $display("FAIL tready_before_edge: %b, required 0", s_tready);
    end
    @(negedge aclk);
    checks++;
    if (s_tready !== 1'b1) begin
      errors++;
      $display("FAIL tready_after_edge: %b, required 1", s_tready);
    end
  endtask

  task automatic test_single_write();
    int aw0, w0, e0;
    bit ok;
    aw0 = aw_cnt; w0 = w_q.size(); e0 = wr_err_cnt;
    aw_dly = 0; w_dly = 2; b_dly = 0; bresp_cfg = 2'b00;
    stream_send(32'hDEAD_BEEF, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_write_send: handshake=%b, required 1", ok); end
    wait_b(1, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_write_b: b_cnt=%0d, required 1", b_cnt); end
    repeat (3) @(negedge aclk);
    checks++;
    if (aw_cnt - aw0 != 1 || last_awaddr !== 32'h0000_0001) begin
      errors++;
      $display("FAIL single_write_aw: count=%0d addr=%h, required 1 / 00000001", aw_cnt - aw0, last_awaddr);
    end
    checks++;
    if (w_q.size() - w0 != 1 || w_q[w_q.size()-1] !== 32'hDEAD_BEEF || last_wstrb !== 4'hF) begin
      errors++;
      $display("FAIL single_write_w: count=%0d data=%h strb=%h, required 1 / deadbeef / f",
               w_q.size() - w0, w_q[w_q.size()-1], last_wstrb);
    end
    checks++;
    if (wr_err_cnt != e0) begin
      errors++;
      $display("FAIL single_write_err: wr_err cycles=%0d, required 0", wr_err_cnt - e0);
    end
  endtask

  task automatic test_write_error();
    int aw0, e0;
    bit ok;
    aw0 = aw_cnt; e0 = wr_err_cnt;
    aw_dly = 0; w_dly = 0; b_dly = 0; bresp_cfg = 2'b11;
    stream_send(32'h0BAD_F00D, ok);
    // now in the cycle after the stream handshake
    checks++;
    if (!ok || awvalid !== 1'b1 || wvalid !== 1'b1 || s_tready !== 1'b0) begin
      errors++;
      $display("FAIL wr_lat_n1: ok=%b awvalid=%b wvalid=%b tready=%b, required 1/1/1/0", ok, awvalid, wvalid, s_tready);
    end
    @(negedge aclk);
    checks++;
    if (bready !== 1'b1 || awvalid !== 1'b0 || wvalid !== 1'b0) begin
      errors++;
      $display("FAIL wr_lat_n2: bready=%b awvalid=%b wvalid=%b, required 1/0/0", bready, awvalid, wvalid);
    end
    @(negedge aclk);
    checks++;
    if (s_tready !== 1'b1 || bready !== 1'b0 || wr_err !== 1'b1) begin
      errors++;
      $display("FAIL wr_lat_n3: tready=%b bready=%b wr_err=%b, required 1/0/1", s_tready, bready, wr_err);
    end
    @(negedge aclk);
    checks++;
    if (wr_err !== 1'b0) begin
      errors++;
      $display("FAIL wr_err_width: wr_err=%b one cycle later, required 0", wr_err);
    end
    repeat (6) @(negedge aclk);
    checks++;
    if (aw_cnt - aw0 != 1 || wr_err_cnt - e0 != 1) begin
      errors++;
      $display("FAIL wr_err_no_retry: aw=%0d err_cycles=%0d, required 1 / 1", aw_cnt - aw0, wr_err_cnt - e0);
    end
    bresp_cfg = 2'b00;
  endtask

  task automatic test_read_latency();
    int ar0, rx0;
    ar0 = ar_cnt; rx0 = rx_q.size();
    ar_dly = 0; r_dly = 0; rresp_cfg = 2'b00; r_next = 32'hA5A5_0001; m_mode = 1;
    @(negedge aclk);
    rd_en = 1'b1;
    @(negedge aclk);
    rd_en = 1'b0;
    checks++;
    if (arvalid !== 1'b1 || araddr !== 32'h0000_0001) begin
      errors++;
      $display("FAIL rd_lat_ar: arvalid=%b araddr=%h, required 1 / 00000001", arvalid, araddr);
    end
    @(negedge aclk);
    checks++;
    if (arvalid !== 1'b0 || rready !== 1'b1) begin
      errors++;
      $display("FAIL rd_lat_r: arvalid=%b rready=%b, required 0/1", arvalid, rready);
    end
    @(negedge aclk);
    checks++;
    if (m_tvalid !== 1'b1 || m_tdata !== 32'hA5A5_0001 || rready !== 1'b0) begin
      errors++;
      $display("FAIL rd_lat_push: tvalid=%b tdata=%h rready=%b, required 1 / a5a50001 / 0", m_tvalid, m_tdata, rready);
    end
    @(negedge aclk);
    checks++;
    if (m_tvalid !== 1'b0 || m_tdata !== 32'h0) begin
      errors++;
      $display("FAIL rd_push_clear: tvalid=%b tdata=%h, required 0 / 00000000", m_tvalid, m_tdata);
    end
    repeat (5) @(negedge aclk);
    checks++;
    if (ar_cnt - ar0 != 1 || rx_q.size() - rx0 != 1 || last_araddr !== 32'h0000_0001) begin
      errors++;
      $display("FAIL rd_en_single: ar=%0d words=%0d araddr=%h, required 1 / 1 / 00000001",
               ar_cnt - ar0, rx_q.size() - rx0, last_araddr);
    end
  endtask

  task automatic test_read_error();
    int rx0, e0;
    rx0 = rx_q.size(); e0 = rd_err_cnt;
    rresp_cfg = 2'b11; r_next = 32'hFFFF_FFFF; m_mode = 1;
    rd_en = 1'b1;
    repeat (3) @(negedge aclk);
    checks++;
    if (rd_err !== 1'b1 || m_tvalid !== 1'b0 || arvalid !== 1'b0) begin
      errors++;
      $display("FAIL rd_err_pulse: rd_err=%b tvalid=%b arvalid=%b, required 1/0/0", rd_err, m_tvalid, arvalid);
    end
    @(negedge aclk);
    rd_en = 1'b0;
    checks++;
    if (rd_err !== 1'b0 || arvalid !== 1'b1) begin
      errors++;
      $display("FAIL rd_err_next_ar: rd_err=%b arvalid=%b, required 0/1", rd_err, arvalid);
    end
    repeat (10) @(negedge aclk);
    checks++;
    if (rd_err_cnt - e0 != 2 || rx_q.size() != rx0) begin
      errors++;
      $display("FAIL rd_err_discard: err_cycles=%0d words=%0d, required 2 / 0", rd_err_cnt - e0, rx_q.size() - rx0);
    end
    rresp_cfg = 2'b00;
  endtask

  task automatic test_polled_reads();
    int rx0, ar0;
    bit ok;
    rx0 = rx_q.size(); ar0 = ar_cnt;
    r_next = 32'h1; m_mode = 2;
    rd_en = 1'b1;
    wait_rx(rx0 + 3, ok);
    rd_en = 1'b0;
    repeat (20) @(negedge aclk);
    checks++;
    if (!ok) begin errors++; $display("FAIL polled_count: words=%0d, required 3", rx_q.size() - rx0); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rx_q.size() > rx0 + i && rx_q[rx0+i] !== 32'(i + 1)) begin
        errors++;
        $display("FAIL polled_word%0d: %h, required %h", i, rx_q[rx0+i], 32'(i + 1));
      end
    end
    checks++;
    if (rx_q.size() - rx0 != ar_cnt - ar0) begin
      errors++;
      $display("FAIL polled_all_delivered: words=%0d, required %0d", rx_q.size() - rx0, ar_cnt - ar0);
    end
    m_mode = 1;
  endtask

  task automatic test_back_to_back();
    int aw0, w0, b0, ar0, rx0, e0;
    bit ok;
    aw0 = aw_cnt; w0 = w_q.size(); b0 = b_cnt; ar0 = ar_cnt; rx0 = rx_q.size(); e0 = wr_err_cnt;
    rand_mode = 1; m_mode = 3; r_next = 32'd100;
    rd_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      stream_send(32'hC0DE_0000 + 32'(i), ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL b2b_send%0d: handshake=%b, required 1", i, ok); end
      repeat ($urandom_range(0, 3)) @(negedge aclk);
    end
    wait_b(b0 + 8, ok);
    rd_en = 1'b0;
    repeat (30) @(negedge aclk);
    checks++;
    if (!ok || aw_cnt - aw0 != 8 || w_q.size() - w0 != 8 || wr_err_cnt != e0) begin
      errors++;
      $display("FAIL b2b_writes: aw=%0d w=%0d b=%0d err=%0d, required 8/8/8/0",
               aw_cnt - aw0, w_q.size() - w0, b_cnt - b0, wr_err_cnt - e0);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (w_q.size() > w0 + i && w_q[w0+i] !== 32'hC0DE_0000 + 32'(i)) begin
        errors++;
        $display("FAIL b2b_wdata%0d: %h, required %h", i, w_q[w0+i], 32'hC0DE_0000 + 32'(i));
      end
    end
    checks++;
    if (rx_q.size() == rx0 || rx_q.size() - rx0 != ar_cnt - ar0) begin
      errors++;
      $display("FAIL b2b_reads: words=%0d, required %0d and nonzero", rx_q.size() - rx0, ar_cnt - ar0);
    end
    for (int i = rx0; i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== 32'd100 + 32'(i - rx0)) begin
        errors++;
        $display("FAIL b2b_rdata%0d: %h, required %h", i - rx0, rx_q[i], 32'd100 + 32'(i - rx0));
      end
    end
    rand_mode = 0; m_mode = 1;
  endtask

  task automatic test_async_reset();
    int aw0, rx0;
    bit ok;
    aw_dly = 8; w_dly = 8; m_mode = 0; r_next = 32'h5555_0000; rresp_cfg = 2'b00;
    @(negedge aclk);
    rd_en = 1'b1;
    stream_send(32'hAAAA_0001, ok);
    rd_en = 1'b0;
    repeat (2) @(negedge aclk);
    checks++;
    if (!ok || awvalid !== 1'b1 || m_tvalid !== 1'b1 || m_tdata !== 32'h5555_0000) begin
      errors++;
      $display("FAIL arst_setup: ok=%b awvalid=%b tvalid=%b tdata=%h, required 1/1/1/55550000",
               ok, awvalid, m_tvalid, m_tdata);
    end
    #3;
    aresetn = 1'b0;
    #1;
    checks++;
    if ({s_tready, awvalid, wvalid, bready, arvalid, rready, m_tvalid, wr_err, rd_err} !== 9'b0 ||
        {awaddr, araddr, wdata, m_tdata} !== 128'b0) begin
      errors++;
      $display("FAIL arst_outputs: ctrl=%b awaddr=%h wdata=%h tdata=%h, required all 0",
               {s_tready, awvalid, wvalid, bready, arvalid, rready, m_tvalid, wr_err, rd_err}, awaddr, wdata, m_tdata);
    end
    repeat (12) @(negedge aclk);
    aw_dly = 0; w_dly = 0; m_mode = 1;
    aresetn = 1'b1;
    @(negedge aclk);
    aw0 = aw_cnt; rx0 = rx_q.size();
    stream_send(32'h1234_5678, ok);
    wait_b(b_cnt + 1, ok);
    checks++;
    if (!ok || aw_cnt - aw0 != 1 || w_q[w_q.size()-1] !== 32'h1234_5678) begin
      errors++;
      $display("FAIL arst_restart_wr: aw=%0d wdata=%h, required 1 / 12345678", aw_cnt - aw0, w_q[w_q.size()-1]);
    end
    rd_en = 1'b1;
    @(negedge aclk);
    rd_en = 1'b0;
    wait_rx(rx0 + 1, ok);
    checks++;
    if (!ok || rx_q[rx_q.size()-1] !== 32'h5555_0001) begin
      errors++;
      $display("FAIL arst_restart_rd: word=%h, required 55550001", rx_q[rx_q.size()-1]);
    end
  endtask

  initial begin
    aresetn  = 1'b0;
    rd_en    = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    test_reset();
    test_single_write();
    test_write_error();
    test_read_latency();
    test_read_error();
    test_polled_reads();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
